// File: rtl/ase_emul_pcie_ss_rx_steer.sv
// RX steering fabric: merges the emulator RX stream with NUM_LOCAL local streams and
// routes whole packets to RX-A or RX-B through per-output round-robin arbiters.
module ase_emul_pcie_ss_rx_steer #(
  parameter int NUM_LOCAL    = 2,
  parameter int TDATA_W      = 512,
  parameter int TUSER_W      = 10,
  parameter int FMT_TYPE_LSB = 24,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpl_to_b,
  input  logic [NUM_LOCAL-1:0]           local_to_b,
  input  logic                           s_emul_tvalid,
  output logic                           s_emul_tready,
  input  logic                           s_emul_tlast,
  input  logic [TDATA_W-1:0]             s_emul_tdata,
  input  logic [TDATA_W/8-1:0]           s_emul_tkeep,
  input  logic [TUSER_W-1:0]             s_emul_tuser_vendor,
  input  logic [NUM_LOCAL-1:0]           s_loc_tvalid,
  output logic [NUM_LOCAL-1:0]           s_loc_tready,
  input  logic [NUM_LOCAL-1:0]           s_loc_tlast,
  input  logic [NUM_LOCAL*TDATA_W-1:0]   s_loc_tdata,
  input  logic [NUM_LOCAL*TDATA_W/8-1:0] s_loc_tkeep,
  input  logic [NUM_LOCAL*TUSER_W-1:0]   s_loc_tuser_vendor,
  output logic                           m_a_tvalid,
  input  logic                           m_a_tready,
  output logic                           m_a_tlast,
  output logic [TDATA_W-1:0]             m_a_tdata,
  output logic [TDATA_W/8-1:0]           m_a_tkeep,
  output logic [TUSER_W-1:0]             m_a_tuser_vendor,
  output logic                           m_b_tvalid,
  input  logic                           m_b_tready,
  output logic                           m_b_tlast,
  output logic [TDATA_W-1:0]             m_b_tdata,
  output logic [TDATA_W/8-1:0]           m_b_tkeep,
  output logic [TUSER_W-1:0]             m_b_tuser_vendor,
  output logic [CNT_W-1:0]               pkt_cnt_a,
  output logic [CNT_W-1:0]               pkt_cnt_b
);

  localparam int NSRC   = NUM_LOCAL + 1;
  localparam int SRC_W  = $clog2(NSRC);
  localparam int KEEP_W = TDATA_W / 8;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  // Valid/ready: a beat moves when tvalid && tready at a rising edge; tready is a function
  // of arbiter lock and output-register occupancy only, never of the same source's tvalid.
  logic [NSRC-1:0]    src_valid, src_last, src_to_b, src_ready;
  logic [TDATA_W-1:0] src_data [NSRC];
  logic [KEEP_W-1:0]  src_keep [NSRC];
  logic [TUSER_W-1:0] src_user [NSRC];
  logic [4:0]         emul_type;
  logic               m_ready [2];

  arb_state_e         state_q [2], state_d [2];
  logic [SRC_W-1:0]   grant_q [2], grant_d [2];
  logic [SRC_W-1:0]   ptr_q [2], ptr_d [2];
  logic [NSRC-1:0]    sop_q, sop_d;
  logic               out_valid_q [2], out_valid_d [2];
  logic               out_last_q [2], out_last_d [2];
  logic [TDATA_W-1:0] out_data_q [2], out_data_d [2];
  logic [KEEP_W-1:0]  out_keep_q [2], out_keep_d [2];
  logic [TUSER_W-1:0] out_user_q [2], out_user_d [2];
  logic [CNT_W-1:0]   cnt_q [2], cnt_d [2];

  logic               load [2], fire [2];
  logic [NSRC-1:0]    busy;
  logic [NSRC-1:0]    req [2];
  logic               found;
  int                 idx;

  always_comb begin
    emul_type    = s_emul_tdata[FMT_TYPE_LSB +: 5];
    m_ready[0]   = m_a_tready;
    m_ready[1]   = m_b_tready;
    src_valid[0] = s_emul_tvalid;
    src_last[0]  = s_emul_tlast;
    src_data[0]  = s_emul_tdata;
    src_keep[0]  = s_emul_tkeep;
    src_user[0]  = s_emul_tuser_vendor;
    src_to_b[0]  = cpl_to_b && (emul_type == 5'b01010);
    for (int i = 0; i < NUM_LOCAL; i++) begin
      src_valid[i+1] = s_loc_tvalid[i];
      src_last[i+1]  = s_loc_tlast[i];
      src_data[i+1]  = s_loc_tdata[i*TDATA_W +: TDATA_W];
      src_keep[i+1]  = s_loc_tkeep[i*KEEP_W +: KEEP_W];
      src_user[i+1]  = s_loc_tuser_vendor[i*TUSER_W +: TUSER_W];
      src_to_b[i+1]  = local_to_b[i];
    end
  end

  // A grant is held from the IDLE decision to the EOP beat; that lock is what pins the
  // destination, so a source held by one output is invisible to the other.
  always_comb begin
    busy      = '0;
    src_ready = '0;
    sop_d     = sop_q;
    found     = 1'b0;
    idx       = 0;
    for (int o = 0; o < 2; o++) begin
      if (state_q[o] == ARB_LOCKED) busy[grant_q[o]] = 1'b1;
    end
    for (int o = 0; o < 2; o++) begin
      state_d[o]     = state_q[o];
      grant_d[o]     = grant_q[o];
      ptr_d[o]       = ptr_q[o];
      out_valid_d[o] = out_valid_q[o];
      out_last_d[o]  = out_last_q[o];
      out_data_d[o]  = out_data_q[o];
      out_keep_d[o]  = out_keep_q[o];
      out_user_d[o]  = out_user_q[o];
      cnt_d[o]       = cnt_q[o];

      load[o] = !out_valid_q[o] || m_ready[o];
      fire[o] = (state_q[o] == ARB_LOCKED) && load[o] && src_valid[grant_q[o]];
      req[o]  = src_valid & sop_q & ~busy & ((o == 1) ? src_to_b : ~src_to_b);

      if ((state_q[o] == ARB_LOCKED) && load[o]) src_ready[grant_q[o]] = 1'b1;
      if (load[o]) out_valid_d[o] = fire[o];
      if (fire[o]) begin
        out_last_d[o] = src_last[grant_q[o]];
        out_data_d[o] = src_data[grant_q[o]];
        out_keep_d[o] = src_keep[grant_q[o]];
        out_user_d[o] = src_user[grant_q[o]];
        if (src_last[grant_q[o]]) state_d[o] = ARB_IDLE;
      end

      // Re-arbitrate while idle or on the EOP beat so back-to-back packets lose no cycle.
      if ((state_q[o] == ARB_IDLE) || (fire[o] && src_last[grant_q[o]])) begin
        found = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
          idx = int'(ptr_q[o]) + k;
          if (idx >= NSRC) idx = idx - NSRC;
          if (!found && req[o][idx]) begin
            found      = 1'b1;
            state_d[o] = ARB_LOCKED;
            grant_d[o] = SRC_W'(idx);
            ptr_d[o]   = SRC_W'(idx);
          end
        end
      end

      if (out_valid_q[o] && m_ready[o] && out_last_q[o]) cnt_d[o] = cnt_q[o] + CNT_W'(1);
    end
    for (int s = 0; s < NSRC; s++) begin
      if (src_valid[s] && src_ready[s]) sop_d[s] = src_last[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_q <= '1;
      for (int o = 0; o < 2; o++) begin
        state_q[o]     <= ARB_IDLE;
        grant_q[o]     <= '0;
        ptr_q[o]       <= '0;
        out_valid_q[o] <= 1'b0;
        out_last_q[o]  <= 1'b0;
        out_data_q[o]  <= '0;
        out_keep_q[o]  <= '0;
        out_user_q[o]  <= '0;
        cnt_q[o]       <= '0;
      end
    end else begin
      sop_q <= sop_d;
      for (int o = 0; o < 2; o++) begin
        state_q[o]     <= state_d[o];
        grant_q[o]     <= grant_d[o];
        ptr_q[o]       <= ptr_d[o];
        out_valid_q[o] <= out_valid_d[o];
        out_last_q[o]  <= out_last_d[o];
        out_data_q[o]  <= out_data_d[o];
        out_keep_q[o]  <= out_keep_d[o];
        out_user_q[o]  <= out_user_d[o];
        cnt_q[o]       <= cnt_d[o];
      end
    end
  end

  assign s_emul_tready    = src_ready[0];
  assign s_loc_tready     = src_ready[NSRC-1:1];
  assign m_a_tvalid       = out_valid_q[0];
  assign m_a_tlast        = out_last_q[0];
  assign m_a_tdata        = out_data_q[0];
  assign m_a_tkeep        = out_keep_q[0];
  assign m_a_tuser_vendor = out_user_q[0];
  assign m_b_tvalid       = out_valid_q[1];
  assign m_b_tlast        = out_last_q[1];
  assign m_b_tdata        = out_data_q[1];
  assign m_b_tkeep        = out_keep_q[1];
  assign m_b_tuser_vendor = out_user_q[1];
  assign pkt_cnt_a        = cnt_q[0];
  assign pkt_cnt_b        = cnt_q[1];

endmodule

// File: tb/tb_ase_emul_pcie_ss_rx_steer.sv
// Directed bench for ase_emul_pcie_ss_rx_steer: routing, arbitration order, backpressure,
// counter wrap and mid-packet reset, checked with immediate assertions.
module tb_ase_emul_pcie_ss_rx_steer;
  localparam int NL = 2;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int CW = 10;
  localparam int EW = UW + 1 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cpl_to_b = 1'b0;
  logic [NL-1:0] local_to_b = '0;
  logic s_emul_tvalid = 1'b0, s_emul_tlast = 1'b0;
  logic s_emul_tready;
  logic [DW-1:0] s_emul_tdata = '0;
  logic [KW-1:0] s_emul_tkeep = '1;
  logic [UW-1:0] s_emul_tuser_vendor = '0;
  logic [NL-1:0] s_loc_tvalid = '0, s_loc_tlast = '0;
  logic [NL-1:0] s_loc_tready;
  logic [NL*DW-1:0] s_loc_tdata = '0;
  logic [NL*KW-1:0] s_loc_tkeep = '1;
  logic [NL*UW-1:0] s_loc_tuser_vendor = '0;
  logic m_a_tvalid, m_a_tlast, m_b_tvalid, m_b_tlast;
  logic m_a_tready = 1'b1, m_b_tready = 1'b1;
  logic [DW-1:0] m_a_tdata, m_b_tdata;
  logic [KW-1:0] m_a_tkeep, m_b_tkeep;
  logic [UW-1:0] m_a_tuser_vendor, m_b_tuser_vendor;
  logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [EW-1:0] got_a[$], got_b[$];
  logic [EW-1:0] exp_a_q[$], exp_b_q[$];
  int cyc_a[$], cyc_b[$];
  int order[3] = '{1, 2, 0};

  ase_emul_pcie_ss_rx_steer #(
    .NUM_LOCAL(NL), .TDATA_W(DW), .TUSER_W(UW), .FMT_TYPE_LSB(24), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpl_to_b(cpl_to_b), .local_to_b(local_to_b),
    .s_emul_tvalid(s_emul_tvalid), .s_emul_tready(s_emul_tready), .s_emul_tlast(s_emul_tlast),
    .s_emul_tdata(s_emul_tdata), .s_emul_tkeep(s_emul_tkeep),
    .s_emul_tuser_vendor(s_emul_tuser_vendor),
    .s_loc_tvalid(s_loc_tvalid), .s_loc_tready(s_loc_tready), .s_loc_tlast(s_loc_tlast),
    .s_loc_tdata(s_loc_tdata), .s_loc_tkeep(s_loc_tkeep), .s_loc_tuser_vendor(s_loc_tuser_vendor),
    .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready), .m_a_tlast(m_a_tlast),
    .m_a_tdata(m_a_tdata), .m_a_tkeep(m_a_tkeep), .m_a_tuser_vendor(m_a_tuser_vendor),
    .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready), .m_b_tlast(m_b_tlast),
    .m_b_tdata(m_b_tdata), .m_b_tkeep(m_b_tkeep), .m_b_tuser_vendor(m_b_tuser_vendor),
    .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
  );

  // Clock / reset support
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a beat seen valid&&ready at the falling edge transfers at the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_a_tvalid && m_a_tready) begin
        got_a.push_back({m_a_tuser_vendor, m_a_tlast, m_a_tdata});
        cyc_a.push_back(cyc);
      end
      if (m_b_tvalid && m_b_tready) begin
        got_b.push_back({m_b_tuser_vendor, m_b_tlast, m_b_tdata});
        cyc_b.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] mk(input int s, input int p, input int b, input logic [7:0] fmt);
    return {8'(s), 8'(p), 16'(b), fmt, 24'h0};
  endfunction

  function automatic logic [EW-1:0] ent(input int s, input logic last, input logic [DW-1:0] d);
    return {UW'(s), last, d};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    got_a.delete(); got_b.delete(); cyc_a.delete(); cyc_b.delete();
    exp_a_q.delete(); exp_b_q.delete();
  endtask

  // Driver tasks
  task automatic drive(input int s, input logic v, input logic [DW-1:0] d, input logic last);
    if (s == 0) begin
      s_emul_tvalid = v; s_emul_tdata = d; s_emul_tlast = last;
      s_emul_tuser_vendor = UW'(s);
    end else begin
      s_loc_tvalid[s-1] = v;
      s_loc_tdata[(s-1)*DW +: DW] = d;
      s_loc_tlast[s-1] = last;
      s_loc_tuser_vendor[(s-1)*UW +: UW] = UW'(s);
    end
  endtask

  task automatic send_beat(input int s, input logic [DW-1:0] d, input logic last);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    drive(s, 1'b1, d, last);
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = (s == 0) ? s_emul_tready : s_loc_tready[s-1];
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    assert (acc === 1'b1) else begin
      fails++;
      $error("FAIL accept_timeout: src %0d beat not accepted, got %0b expected 1", s, acc);
    end
  endtask

  task automatic send_pkt(input int s, input int p, input int nb, input logic [7:0] fmt);
    for (int b = 0; b < nb; b++) send_beat(s, mk(s, p, b, fmt), (b == nb - 1));
    drive(s, 1'b0, '0, 1'b0);
  endtask

  // Scoreboard comparison of collected beats against the expected queue
  task automatic check_q(input int which, input string tag);
    logic [EW-1:0] g[$];
    logic [EW-1:0] e[$];
    if (which == 0) begin g = got_a; e = exp_a_q; end
    else begin g = got_b; e = exp_b_q; end
    chk($sformatf("%s_len", tag), 80'(g.size()), 80'(e.size()));
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 80'(g[i]), 80'(e[i]));
  endtask

  initial begin
    // Reset
    #3 rst_n = 1'b0;
    #2;
    chk("rst_a_valid", 80'(m_a_tvalid), 80'(0));
    chk("rst_b_valid", 80'(m_b_tvalid), 80'(0));
    chk("rst_a_data", 80'(m_a_tdata), 80'(0));
    chk("rst_emul_ready", 80'(s_emul_tready), 80'(0));
    chk("rst_loc_ready", 80'(s_loc_tready), 80'(0));
    chk("rst_cnt_a", 80'(pkt_cnt_a), 80'(0));
    chk("rst_cnt_b", 80'(pkt_cnt_b), 80'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // Single-beat emulator MRd with cpl_to_b=1 stays on RX-A
    clear_sb();
    cpl_to_b = 1'b1;
    send_pkt(0, 1, 1, 8'h20);
    chk("t2_a_valid", 80'(m_a_tvalid), 80'(1));
    chk("t2_a_data", 80'(m_a_tdata), 80'(mk(0, 1, 0, 8'h20)));
    chk("t2_a_keep", 80'(m_a_tkeep), 80'(8'hFF));
    chk("t2_b_valid", 80'(m_b_tvalid), 80'(0));
    wait_cycles(1);
    chk("t2_cnt_a", 80'(pkt_cnt_a), 80'(1));
    chk("t2_cnt_b", 80'(pkt_cnt_b), 80'(0));

    // 3-beat CplD to RX-B with cpl_to_b dropped mid-packet; the next CplD goes to RX-A
    clear_sb();
    cpl_to_b = 1'b1;
    send_beat(0, mk(0, 2, 0, 8'h4A), 1'b0);
    cpl_to_b = 1'b0;
    send_beat(0, mk(0, 2, 1, 8'h4A), 1'b0);
    send_beat(0, mk(0, 2, 2, 8'h4A), 1'b1);
    drive(0, 1'b0, '0, 1'b0);
    send_pkt(0, 3, 1, 8'h4A);
    wait_cycles(3);
    for (int b = 0; b < 3; b++) exp_b_q.push_back(ent(0, (b == 2), mk(0, 2, b, 8'h4A)));
    exp_a_q.push_back(ent(0, 1'b1, mk(0, 3, 0, 8'h4A)));
    check_q(1, "t3_b");
    check_q(0, "t3_a");
    if (cyc_b.size() == 3) chk("t3_b_contig", 80'(cyc_b[2] - cyc_b[0]), 80'(2));

    // Three sources streaming 2-beat packets to RX-A: order 1,2,0 with no gaps
    clear_sb();
    local_to_b = 2'b00;
    fork
      begin for (int r = 0; r < 3; r++) send_pkt(0, 10 + r, 2, 8'h20); end
      begin for (int r = 0; r < 3; r++) send_pkt(1, 10 + r, 2, 8'h00); end
      begin for (int r = 0; r < 3; r++) send_pkt(2, 10 + r, 2, 8'h00); end
    join
    wait_cycles(3);
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        for (int b = 0; b < 2; b++)
          exp_a_q.push_back(ent(order[j], (b == 1),
                                mk(order[j], 10 + r, b, (order[j] == 0) ? 8'h20 : 8'h00)));
    check_q(0, "t4_a");
    chk("t4_b_len", 80'(got_b.size()), 80'(0));
    if (cyc_a.size() == 18) chk("t4_throughput", 80'(cyc_a[17] - cyc_a[0]), 80'(17));

    // Local 0 to RX-B and emulator MRd to RX-A issued together
    clear_sb();
    local_to_b = 2'b01;
    fork
      send_pkt(1, 20, 1, 8'h00);
      send_pkt(0, 21, 1, 8'h20);
    join
    chk("t5_a_valid", 80'(m_a_tvalid), 80'(1));
    chk("t5_b_valid", 80'(m_b_tvalid), 80'(1));
    wait_cycles(3);
    exp_a_q.push_back(ent(0, 1'b1, mk(0, 21, 0, 8'h20)));
    exp_b_q.push_back(ent(1, 1'b1, mk(1, 20, 0, 8'h00)));
    check_q(0, "t5_a");
    check_q(1, "t5_b");

    // RX-B backpressure for 5 cycles mid-packet
    clear_sb();
    send_beat(1, mk(1, 30, 0, 8'h00), 1'b0);
    m_b_tready = 1'b0;
    drive(1, 1'b1, mk(1, 30, 1, 8'h00), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t6_hold_data%0d", i), 80'(m_b_tdata), 80'(mk(1, 30, 0, 8'h00)));
      chk($sformatf("t6_hold_ready%0d", i), 80'(s_loc_tready[0]), 80'(0));
    end
    m_b_tready = 1'b1;
    send_beat(1, mk(1, 30, 1, 8'h00), 1'b0);
    send_beat(1, mk(1, 30, 2, 8'h00), 1'b0);
    send_beat(1, mk(1, 30, 3, 8'h00), 1'b1);
    drive(1, 1'b0, '0, 1'b0);
    wait_cycles(3);
    for (int b = 0; b < 4; b++) exp_b_q.push_back(ent(1, (b == 3), mk(1, 30, b, 8'h00)));
    check_q(1, "t6_b");

    // Counter wrap on RX-A
    chk("t7_cnt_a_pre", 80'(pkt_cnt_a), 80'(12));
    chk("t7_cnt_b_pre", 80'(pkt_cnt_b), 80'(3));
    for (int i = 0; i < 1011; i++) send_pkt(0, 0, 1, 8'h20);
    wait_cycles(2);
    chk("t7_cnt_a_max", 80'(pkt_cnt_a), 80'(10'h3FF));
    send_pkt(0, 0, 1, 8'h20);
    wait_cycles(2);
    chk("t7_cnt_a_wrap", 80'(pkt_cnt_a), 80'(0));
    chk("t7_cnt_b_keep", 80'(pkt_cnt_b), 80'(3));

    // Reset mid-packet, then a clean packet from the same source to the other output
    clear_sb();
    local_to_b = 2'b00;
    send_beat(2, mk(2, 40, 0, 8'h00), 1'b0);
    send_beat(2, mk(2, 40, 1, 8'h00), 1'b0);
    chk("t8_a_valid_pre", 80'(m_a_tvalid), 80'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_a_valid", 80'(m_a_tvalid), 80'(0));
    chk("t8_rst_a_data", 80'(m_a_tdata), 80'(0));
    chk("t8_rst_a_last", 80'(m_a_tlast), 80'(0));
    chk("t8_rst_loc_ready", 80'(s_loc_tready), 80'(0));
    chk("t8_rst_cnt_a", 80'(pkt_cnt_a), 80'(0));
    drive(2, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    local_to_b = 2'b10;
    wait_cycles(1);
    clear_sb();
    send_pkt(2, 41, 1, 8'h00);
    wait_cycles(3);
    exp_b_q.push_back(ent(2, 1'b1, mk(2, 41, 0, 8'h00)));
    check_q(1, "t8_b");
    check_q(0, "t8_a");
    chk("t8_cnt_b", 80'(pkt_cnt_b), 80'(1));
    chk("t8_cnt_a", 80'(pkt_cnt_a), 80'(0));

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ase_emul_pcie_ss_rx_steer.md
Name: ase_emul_pcie_ss_rx_steer

Overview:
- Parametrised RX-side steering fabric between the ASE PCIe SS emulator RX stream and the AFU-facing RX-A/RX-B streams.
- Merges the emulator stream with NUM_LOCAL locally synthesised streams (write commits, emulated interrupts acks) and routes each packet to RX-A or RX-B.
- Routing is selected at runtime per class, generalising the fixed two-channel commit/completion routing.
- Each output has a packet-atomic round-robin arbiter, a registered output stage and a wrapping packet counter.

Parameters:
- NUM_LOCAL, 2, number of local (FIM-synthesised) input streams, 1..8
- TDATA_W, 512, AXI-S tdata width; tkeep width is TDATA_W/8
- TUSER_W, 10, tuser_vendor width
- FMT_TYPE_LSB, 24, bit offset of the 8-bit TLP fmt_type field in SOP tdata
- CNT_W, 16, width of per-output packet counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpl_to_b  in  1  route emulator completions to RX-B (else RX-A)
- local_to_b  in  NUM_LOCAL  per local stream: route to RX-B (else RX-A)
- s_emul_tvalid/tready/tlast  in/out/in  1  emulator RX stream handshake
- s_emul_tdata/tkeep/tuser_vendor  in  TDATA_W/TDATA_W/8/TUSER_W  emulator RX payload
- s_loc_tvalid/tready/tlast  in/out/in  NUM_LOCAL each  local stream handshakes, bit i = stream i
- s_loc_tdata/tkeep/tuser_vendor  in  NUM_LOCAL*(TDATA_W/TDATA_W/8/TUSER_W)  packed local payloads, stream i at slice i
- m_a_tvalid/tready/tlast  out/in/out  1  RX-A output handshake
- m_a_tdata/tkeep/tuser_vendor  out  TDATA_W/TDATA_W/8/TUSER_W  RX-A payload
- m_b_* , same as m_a_*, RX-B output
- pkt_cnt_a, pkt_cnt_b  out  CNT_W  EOP beats delivered on RX-A/RX-B

Behaviour:
- Reset (async assert, sync release): m_a/m_b tvalid=0; tlast/tdata/tkeep/tuser_vendor=0; s_*_tready=0; pkt counters=0; arbiter pointers=source 0; all SOP flags=1; no lock held.
- Sources indexed 0=emulator, 1..NUM_LOCAL=local streams.
- Classification at SOP only:
  - Emulator packet goes to RX-B iff cpl_to_b=1 and fmt_type[4:0]==5'b01010 (Cpl/CplD, any fmt); otherwise RX-A.
  - Local stream i goes to RX-B iff local_to_b[i].
  - The destination is latched at SOP for the whole packet; config changes mid-packet take effect at the next SOP of that source.
- Arbitration per output:
  - States IDLE, LOCKED(src).
  - IDLE: grant the first requesting source at or after pointer+1 (wrapping) whose SOP destination is this output; move to LOCKED(src), pointer=src.
  - LOCKED: forward only src beats. On an accepted beat with tlast, return to IDLE; a new grant is possible the same cycle.
  - No beat interleaving across packets on one output.
  - The emulator stream is granted by at most one output at a time, by construction of its single latched destination.
- Output stage: one register per output. Load when !m_tvalid || m_tready, so full throughput with one bubble-free beat per cycle. Latency from input acceptance to m_tvalid is 1 cycle.
- Input handshakes:
  - s_tready=1 only for the granted source when its output register can load.
  - A source's tready never depends on its own tvalid.
- Holding: once m_tvalid=1, payload is held stable until m_tready.
- Counters: pkt_cnt_x increments on m_x_tvalid&&m_x_tready&&m_x_tlast and wraps at 2^CNT_W-1 → 0.
- Simultaneous events:
  - Packets to A and B from different sources proceed in parallel.
  - EOP and a new grant in the same cycle lose no cycle.
- Reset mid-packet: all state is discarded immediately; no partial beat is presented after release.

Test Plan:
- Single-beat emulator MRd SOP (fmt_type 8'h20), cpl_to_b=1 -> appears on RX-A after 1 cycle, pkt_cnt_a=1, RX-B idle.
- 3-beat emulator CplD (8'h4A), cpl_to_b=1, then cpl_to_b=0 toggled on beat 2 -> all 3 beats on RX-B contiguous; the next CplD goes to RX-A.
- NUM_LOCAL=2, both locals plus emulator streaming 2-beat packets continuously to RX-A, m_a_tready=1 -> grant order 1,2,0,1,2,0…, no interleaving, 100% beat throughput.
- Local 0 to RX-B and emulator MRd to RX-A issued the same cycle -> both outputs valid the next cycle, independent progress.
- m_b_tready held low 5 cycles mid-packet -> payload stable, s_loc_tready[0]=0 while the register is full; no beats lost or duplicated.
- pkt_cnt_a preloaded via 65535 packets (CNT_W=16) -> the next EOP wraps it to 0. Assert rst_n mid-packet -> outputs drop to 0 asynchronously, the next packet after release starts clean at SOP.
